rtc_bus_cycle_ctrl: RTL

Bus-cycle controller between the RTC sequencing FSM and the external RTC chip's multiplexed address/data bus. It accepts one register transaction at a time as enable, write/read, address and write data. It generates the address-latch phase and data phase with programmable strobe widths, and captures read data. It returns a one-cycle done pulse, which the sequencer's transaction counter uses to step to the next register.

---
 rtl/rtc_bus_cycle_ctrl_pkg.sv | 33 +++
 rtl/rtc_bus_cycle_ctrl_if.sv | 31 +++
 rtl/rtc_bus_cycle_ctrl_phase_timer.sv | 23 ++
 rtl/rtc_bus_cycle_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_cycle_ctrl_pkg.sv
// Shared types and constants for the RTC bus-cycle controller.
// Also holds the BCD validity helper used by the display decoder.
package rtc_bus_pkg;

  localparam int PHASE_CYC_DEF = 10;
  localparam int TURN_CYC_DEF  = 2;

  // Registers at or above this address hold commands/status, not BCD data
  localparam logic [7:0] CMD_ADDR_BASE = 8'hF0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_A_STB  = 3'd1;
  localparam logic [2:0] S_A_HOLD = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_D_STB  = 3'd4;
  localparam logic [2:0] S_D_HOLD = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_A_STB  = S_A_STB,
    ST_A_HOLD = S_A_HOLD,
    ST_GAP    = S_GAP,
    ST_D_STB  = S_D_STB,
    ST_D_HOLD = S_D_HOLD,
    ST_DONE   = S_DONE
  } state_t;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_bus_cycle_ctrl_if.sv
// Sequencer request and RTC bus signals of the bus-cycle controller.
// master = sequencer side, slave = controller side.
interface rtc_bus_cycle_ctrl_if;
  logic       in_en_funcion_rtc;
  logic       in_funcion_w_r;
  logic [7:0] in_addr_ram_rtc;
  logic [7:0] in_dato_escritura;
  logic [7:0] in_ad;
  logic [7:0] out_ad;
  logic       out_ad_oe;
  logic       out_cs_n;
  logic       out_rd_n;
  logic       out_wr_n;
  logic       out_a_d;
  logic       out_flag_done;
  logic [7:0] out_dato_leido;
  logic       out_busy;
  logic       out_bcd_err;

  modport master (
    output in_en_funcion_rtc, in_funcion_w_r, in_addr_ram_rtc, in_dato_escritura, in_ad,
    input  out_ad, out_ad_oe, out_cs_n, out_rd_n, out_wr_n, out_a_d,
           out_flag_done, out_dato_leido, out_busy, out_bcd_err
  );

  modport slave (
    input  in_en_funcion_rtc, in_funcion_w_r, in_addr_ram_rtc, in_dato_escritura, in_ad,
    output out_ad, out_ad_oe, out_cs_n, out_rd_n, out_wr_n, out_a_d,
           out_flag_done, out_dato_leido, out_busy, out_bcd_err
  );
endinterface

// File: rtl/rtc_bus_cycle_ctrl_phase_timer.sv
// 8-bit load/decrement phase counter; zero flags the last cycle of a phase.
module rtc_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= 8'd0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != 8'd0)) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign zero = (count_reg == 8'd0);
endmodule

// File: rtl/rtc_bus_cycle_ctrl.sv
// Multiplexed address/data bus-cycle controller for the external RTC chip.
// Optional read-data BCD check is built when RTC_BCD_CHECK_EN is defined.
module rtc_bus_cycle_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = PHASE_CYC_DEF,
  parameter int TURN_CYC  = TURN_CYC_DEF
) (
  input logic                clk,
  input logic                reset,
  rtc_bus_cycle_ctrl_if.slave bus
);
  localparam logic [7:0] PHASE_LOAD = 8'(PHASE_CYC - 1);
  localparam logic [7:0] TURN_LOAD  = 8'(TURN_CYC - 1);

  state_t     state_reg;
  logic       w_r_reg;
  logic [7:0] addr_reg, data_reg;
  logic       cs_n_reg, rd_n_reg, wr_n_reg, a_d_reg, oe_reg;
  logic [7:0] ad_reg, leido_reg;
  logic       done_reg, busy_reg;
  logic       timed, timer_load, timer_dec, timer_zero;
  logic [7:0] timer_val;

  always_comb begin
    timed      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    timer_load = 1'b0;
    timer_val  = PHASE_LOAD;
    if (state_reg == ST_IDLE) begin
      timer_load = bus.in_en_funcion_rtc;
    end else if (timed) begin
      timer_load = timer_zero;
    end
    // Leaving A_HOLD enters the turnaround gap
    if (state_reg == ST_A_HOLD) begin
      timer_val = TURN_LOAD;
    end
  end

  assign timer_dec = timed && !timer_zero;

  rtc_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

`ifdef RTC_BCD_CHECK_EN
  logic bcd_err_reg;
  assign bus.out_bcd_err = bcd_err_reg;
`else
  assign bus.out_bcd_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      w_r_reg   <= 1'b0;
      addr_reg  <= 8'h00;
      data_reg  <= 8'h00;
      cs_n_reg  <= 1'b1;
      rd_n_reg  <= 1'b1;
      wr_n_reg  <= 1'b1;
      a_d_reg   <= 1'b1;
      oe_reg    <= 1'b0;
      ad_reg    <= 8'h00;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      leido_reg <= 8'h00;
`ifdef RTC_BCD_CHECK_EN
      bcd_err_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
      bcd_err_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_en_funcion_rtc) begin
            state_reg <= ST_A_STB;
            w_r_reg   <= bus.in_funcion_w_r;
            addr_reg  <= bus.in_addr_ram_rtc;
            data_reg  <= bus.in_dato_escritura;
            cs_n_reg  <= 1'b0;
            a_d_reg   <= 1'b0;
            wr_n_reg  <= 1'b0;
            oe_reg    <= 1'b1;
            ad_reg    <= bus.in_addr_ram_rtc;
            busy_reg  <= 1'b1;
          end
        end
        ST_A_STB: begin
          ad_reg <= addr_reg;
          if (timer_zero) begin
            state_reg <= ST_A_HOLD;
            wr_n_reg  <= 1'b1;
          end
        end
        ST_A_HOLD: begin
          // a_d flips only here, with cs_n released and the bus floated
          if (timer_zero) begin
            state_reg <= ST_GAP;
            cs_n_reg  <= 1'b1;
            a_d_reg   <= 1'b1;
            oe_reg    <= 1'b0;
            ad_reg    <= 8'h00;
          end
        end
        ST_GAP: begin
          if (timer_zero) begin
            state_reg <= ST_D_STB;
            cs_n_reg  <= 1'b0;
            if (w_r_reg) begin
              wr_n_reg <= 1'b0;
              oe_reg   <= 1'b1;
              ad_reg   <= data_reg;
            end else begin
              rd_n_reg <= 1'b0;
            end
          end
        end
        ST_D_STB: begin
          if (timer_zero) begin
            state_reg <= ST_D_HOLD;
            wr_n_reg  <= 1'b1;
            rd_n_reg  <= 1'b1;
            if (!w_r_reg) begin
              leido_reg <= bus.in_ad;
            end
          end
        end
        ST_D_HOLD: begin
          if (timer_zero) begin
            state_reg <= ST_DONE;
            cs_n_reg  <= 1'b1;
            oe_reg    <= 1'b0;
            ad_reg    <= 8'h00;
            done_reg  <= 1'b1;
`ifdef RTC_BCD_CHECK_EN
            bcd_err_reg <= !w_r_reg && (addr_reg < CMD_ADDR_BASE) && !bcd_valid(leido_reg);
`endif
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_ad         = ad_reg;
  assign bus.out_ad_oe      = oe_reg;
  assign bus.out_cs_n       = cs_n_reg;
  assign bus.out_rd_n       = rd_n_reg;
  assign bus.out_wr_n       = wr_n_reg;
  assign bus.out_a_d        = a_d_reg;
  assign bus.out_flag_done  = done_reg;
  assign bus.out_dato_leido = leido_reg;
  assign bus.out_busy       = busy_reg;
endmodule
